// File: rtl/jtag_dr_engine.sv
// JTAG data-register engine: synchronises raw TAP signals into clk_50_, runs the
// DR shift chain and turns IR opcodes into memory read/write and flag commands.
module jtag_dr_engine #(
  parameter int                    IR_LENGTH   = 4,
  parameter int                    DR_WIDTH    = 32,
  parameter int                    FLAG_WIDTH  = 8,
  parameter logic [DR_WIDTH-1:0]   IDENT_VALUE = 32'h4A544147,
  parameter logic [IR_LENGTH-1:0]  IIDENT      = IR_LENGTH'(1),
  parameter logic [IR_LENGTH-1:0]  IRADDR      = IR_LENGTH'(2),
  parameter logic [IR_LENGTH-1:0]  IWADDR      = IR_LENGTH'(3),
  parameter logic [IR_LENGTH-1:0]  IWDATA      = IR_LENGTH'(4),
  parameter logic [IR_LENGTH-1:0]  IRDATA      = IR_LENGTH'(5),
  parameter logic [IR_LENGTH-1:0]  IFLAGS      = IR_LENGTH'(6)
) (
  input  logic                  clk_50_,
  input  logic                  reset_n,
  input  logic                  tck,
  input  logic                  tdi,
  input  logic                  tms,
  input  logic [IR_LENGTH-1:0]  ir,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  tdo,
  output logic                  mem_wr_en,
  output logic [DR_WIDTH-1:0]   mem_wr_addr,
  output logic [DR_WIDTH-1:0]   mem_wr_data,
  output logic [DR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DR_WIDTH-1:0]   mem_rd_data,
  output logic [FLAG_WIDTH-1:0] flags,
  output logic [7:0]            tapsigs_d
);

  localparam int CW = $clog2(DR_WIDTH + 1);
  localparam logic [CW-1:0] BC_FULL = CW'(DR_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  logic [1:0] rst_q;
  logic       rst_n;

  // Reset asserts asynchronously but releases two clocks later.
  always_ff @(posedge clk_50_ or negedge reset_n) begin
    if (!reset_n) rst_q <= '0;
    else          rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  // Bit order: {tck, tdi, tms, capture, shift, update}
  logic [5:0]           tap_s1_q, tap_s2_q;
  logic [IR_LENGTH-1:0] ir_s1_q, ir_s2_q;
  logic                 tck_s3_q;

  always_ff @(posedge clk_50_ or negedge rst_n) begin
    if (!rst_n) begin
      tap_s1_q <= '0;
      tap_s2_q <= '0;
      ir_s1_q  <= '0;
      ir_s2_q  <= '0;
      tck_s3_q <= 1'b0;
    end else begin
      tap_s1_q <= {tck, tdi, tms, capture_dr, shift_dr, update_dr};
      tap_s2_q <= tap_s1_q;
      ir_s1_q  <= ir;
      ir_s2_q  <= ir_s1_q;
      tck_s3_q <= tap_s2_q[5];
    end
  end

  logic tck_rise, tdi_s, cap_s, sh_s, upd_s;
  assign tck_rise  = tap_s2_q[5] & ~tck_s3_q;
  assign tdi_s     = tap_s2_q[4];
  assign cap_s     = tap_s2_q[2];
  assign sh_s      = tap_s2_q[1];
  assign upd_s     = tap_s2_q[0];
  assign tapsigs_d = {tap_s2_q, tck_rise, 1'b0};

  state_e               state_q, state_d;
  logic [DR_WIDTH-1:0]  sr_q, sr_d, raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DR_WIDTH-1:0]  wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [IR_LENGTH-1:0] ir_q, ir_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic                 tdo_q, tdo_d, wr_en_q, wr_en_d;
  logic [DR_WIDTH-1:0]  cap_val, v;
  logic [CW-1:0]        shamt;

  always_comb begin
    case (ir_s2_q)
      IIDENT:  cap_val = IDENT_VALUE;
      IRADDR:  cap_val = raddr_q;
      IWADDR:  cap_val = waddr_q;
      IRDATA:  cap_val = mem_rd_data;
      IFLAGS:  cap_val = DR_WIDTH'(flags_q);
      default: cap_val = '0;
    endcase
  end

  // Partial shifts leave the received bits in the top of sr; right-align them.
  always_comb begin
    shamt = BC_FULL - bitcnt_q;
    if (bitcnt_q == BC_FULL) v = sr_q;
    else if (bitcnt_q == '0) v = '0;
    else                     v = sr_q >> shamt;
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    ir_d      = ir_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    flags_d   = flags_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (tck_rise && cap_s) begin
          sr_d     = cap_val;
          bitcnt_d = '0;
          ir_d     = ir_s2_q;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (tck_rise) begin
          if (upd_s) begin
            state_d = COMMIT;
          end else if (cap_s) begin
            sr_d     = cap_val;
            bitcnt_d = '0;
            ir_d     = ir_s2_q;
          end else if (sh_s) begin
            sr_d = {tdi_s, sr_q[DR_WIDTH-1:1]};
            if (bitcnt_q != BC_FULL) bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (ir_q == IRDATA) begin
          raddr_d = raddr_q + 1'b1;
        end else if (bitcnt_q != '0) begin
          case (ir_q)
            IRADDR: raddr_d = v;
            IWADDR: waddr_d = v;
            IWDATA: begin
              wr_en_d   = 1'b1;
              wr_addr_d = waddr_q;
              wr_data_d = v;
              waddr_d   = waddr_q + 1'b1;
            end
            IFLAGS:  flags_d = v[FLAG_WIDTH-1:0];
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    tdo_d = sr_d[0];
  end

  always_ff @(posedge clk_50_ or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bitcnt_q  <= '0;
      ir_q      <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      flags_q   <= '0;
      tdo_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      ir_q      <= ir_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      flags_q   <= flags_d;
      tdo_q     <= tdo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign tdo         = tdo_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_addr = raddr_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_jtag_dr_engine.sv
// Directed bench for jtag_dr_engine: drives slow TAP sequences and checks
// serialised tdo data, memory port activity and flags against fixed values.
module tb_jtag_dr_engine;

  localparam logic [3:0] IIDENT = 4'd1, IRADDR = 4'd2, IWADDR = 4'd3;
  localparam logic [3:0] IWDATA = 4'd4, IRDATA = 4'd5, IFLAGS = 4'd6;

  logic        clk_50_ = 1'b0;
  logic        reset_n, tck, tdi, tms, capture_dr, shift_dr, update_dr;
  logic [3:0]  ir;
  logic        tdo, mem_wr_en;
  logic [31:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;
  logic [7:0]  flags, tapsigs_d;

  logic [31:0] mem [0:63];
  int          wr_count = 0;
  logic [31:0] last_addr = '0, last_data = '0;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] dout;

  always #10 clk_50_ = ~clk_50_;

  jtag_dr_engine #(.IR_LENGTH(4), .DR_WIDTH(32), .FLAG_WIDTH(8)) dut (
    .clk_50_(clk_50_), .reset_n(reset_n), .tck(tck), .tdi(tdi), .tms(tms),
    .ir(ir), .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .tdo(tdo), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .flags(flags), .tapsigs_d(tapsigs_d)
  );

  // Synchronous-read memory model with write monitor.
  always @(posedge clk_50_) begin
    mem_rd_data <= mem[mem_rd_addr[5:0]];
    if (mem_wr_en) begin
      wr_count  <= wr_count + 1;
      last_addr <= mem_wr_addr;
      last_data <= mem_wr_data;
      mem[mem_wr_addr[5:0]] <= mem_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk_50_);
  endtask

  task automatic tap_idle();
    tck = 1'b0; tdi = 1'b0; tms = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
  endtask

  task automatic tck_cycle(input logic c, input logic s, input logic u, input logic d);
    capture_dr = c; shift_dr = s; update_dr = u; tdi = d; tms = u;
    clks(4);
    tck = 1'b1;
    clks(4);
    tck = 1'b0;
  endtask

  // Capture under op, switch ir to op_mid, shift n bits of din reading tdo, update.
  task automatic dr_xfer(input logic [3:0] op, input logic [3:0] op_mid, input int n,
                         input logic [31:0] din, output logic [31:0] rd);
    rd = '0;
    ir = op;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    ir = op_mid;
    for (int i = 0; i < n; i++) begin
      rd[i] = tdo;
      tck_cycle(1'b0, 1'b1, 1'b0, din[i]);
    end
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    tap_idle();
    clks(4);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 + i;
    mem[0] = 32'h1234;
    mem[1] = 32'h5678;
    tap_idle();
    ir = '0;
    reset_n = 1'b0;
    clks(5);
    check("reset_tdo", {31'd0, tdo}, 32'd0);
    check("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("reset_flags", {24'd0, flags}, 32'd0);
    check("reset_rd_addr", mem_rd_addr, 32'd0);
    check("reset_tapsigs", {24'd0, tapsigs_d}, 32'd0);
    reset_n = 1'b1;
    clks(6);

    dr_xfer(IIDENT, IIDENT, 32, 32'h0, dout);
    check("ident", dout, 32'h4A544147);
    check("ident_flags", {24'd0, flags}, 32'd0);
    check("ident_no_wr", wr_count, 0);

    dr_xfer(IWADDR, IWADDR, 32, 32'h10, dout);
    check("waddr_cap0", dout, 32'h0);
    dr_xfer(IWDATA, IWDATA, 32, 32'hE0, dout);
    check("wr1_count", wr_count, 1);
    check("wr1_addr", last_addr, 32'h10);
    check("wr1_data", last_data, 32'hE0);

    dr_xfer(IWDATA, IWDATA, 8, 32'hA5, dout);
    check("wr8_count", wr_count, 2);
    check("wr8_addr", last_addr, 32'h11);
    check("wr8_data", last_data, 32'hA5);

    dr_xfer(IWDATA, IWDATA, 0, 32'h0, dout);
    check("wr0_no_write", wr_count, 2);
    dr_xfer(IWADDR, IWADDR, 32, 32'h12, dout);
    check("waddr_after_writes", dout, 32'h12);

    dr_xfer(IRADDR, IRADDR, 32, 32'h0, dout);
    check("raddr_cap0", dout, 32'h0);
    dr_xfer(IRDATA, IRDATA, 32, 32'h0, dout);
    check("rdata0", dout, 32'h1234);
    dr_xfer(IRDATA, IRDATA, 32, 32'h0, dout);
    check("rdata1", dout, 32'h5678);
    check("raddr_end", mem_rd_addr, 32'd2);

    dr_xfer(IFLAGS, IFLAGS, 8, 32'h40, dout);
    check("flags_cap0", dout, 32'h0);
    check("flags_set", {24'd0, flags}, 32'h40);
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    tap_idle();
    clks(6);
    check("orphan_update_flags", {24'd0, flags}, 32'h40);
    check("orphan_update_no_wr", wr_count, 2);

    dr_xfer(IWDATA, IFLAGS, 8, 32'h3C, dout);
    check("irchg_count", wr_count, 3);
    check("irchg_addr", last_addr, 32'h12);
    check("irchg_data", last_data, 32'h3C);
    check("irchg_flags", {24'd0, flags}, 32'h40);

    ir = IWDATA;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    tap_idle();
    reset_n = 1'b0;
    clks(3);
    check("abort_tdo", {31'd0, tdo}, 32'd0);
    reset_n = 1'b1;
    clks(6);
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    tap_idle();
    clks(6);
    check("abort_no_wr", wr_count, 3);
    check("abort_flags", {24'd0, flags}, 32'd0);
    dr_xfer(IWADDR, IWADDR, 32, 32'h0, dout);
    check("abort_waddr", dout, 32'h0);
    dr_xfer(IIDENT, IIDENT, 32, 32'h0, dout);
    check("abort_ident", dout, 32'h4A544147);
    check("final_no_wr", wr_count, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_dr_engine.md
Name: jtag_dr_engine

Overview:
- Sits directly downstream of the virtual-JTAG TAP wrapper.
- Takes the raw TAP outputs (tck, tdi, tms, ir, capture_dr, shift_dr, update_dr), which are asynchronous to the system clock, and synchronises them into clk_50_.
- Implements the data-register shift chain and decodes the instruction register into commands: ident, read-address, write-address, write-data, read-data and flags.
- Drives tdo back to the TAP, a memory write/read port, and a flags register.

Parameters:
- IR_LENGTH, 4, instruction register width; matches the TAP.
- DR_WIDTH, 32, shift chain width; also the memory data and address width.
- FLAG_WIDTH, 8, width of the flags register.
- IDENT_VALUE, 32'h4A544147, constant loaded on capture under IIDENT.
- IIDENT, 1; IRADDR, 2; IWADDR, 3; IWDATA, 4; IRDATA, 5; IFLAGS, 6: IR opcodes.

Ports:
- clk_50_  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tck  input  1  TAP clock, async to clk_50_
- tdi  input  1  TAP serial data in
- tms  input  1  TAP mode, synchronised only, exported for debug
- ir  input  IR_LENGTH  current instruction
- capture_dr  input  1  TAP capture-DR state
- shift_dr  input  1  TAP shift-DR state
- update_dr  input  1  TAP update-DR state
- tdo  output  1  serial data out, equal to sr[0]
- mem_wr_en  output  1  one-cycle write strobe
- mem_wr_addr  output  DR_WIDTH  write address
- mem_wr_data  output  DR_WIDTH  write data
- mem_rd_addr  output  DR_WIDTH  read address, driven continuously from raddr
- mem_rd_data  input  DR_WIDTH  read data, valid one clk after mem_rd_addr changes
- flags  output  FLAG_WIDTH  flags register
- tapsigs_d  output  8  synchronised {tck,tdi,tms,capture,shift,update,tck_rise,0}, for the logger

Behaviour:
- Synchronisation
  - Every TAP input passes through a 2-flop synchroniser; tck gets a third flop.
  - tck_rise = sync2 & ~sync3.
  - All TAP actions occur only in the clk cycle in which tck_rise is high, using the synchronised state bits.
  - Required: f(tck) <= f(clk_50_)/4.
- Reset (reset_n low, asynchronous)
  - sr, bitcnt, raddr, waddr, flags and all sync flops clear to 0.
  - mem_wr_en = 0, tdo = 0, state = IDLE.
  - Deassertion is synchronised internally with a 2-flop release.
- State machine: IDLE -> SHIFT -> COMMIT -> IDLE
  - IDLE: tck_rise & capture → load sr, clear bitcnt, go to SHIFT.
  - SHIFT: tck_rise & shift → sr = {tdi, sr[DR_WIDTH-1:1]} (LSB first); bitcnt increments and saturates at DR_WIDTH.
  - SHIFT: tck_rise & update → go to COMMIT.
  - SHIFT: tck_rise & capture → reload sr and bitcnt (re-capture allowed).
  - COMMIT: lasts exactly one clk, performs the command, then returns to IDLE.
- Capture load by ir:
  - IIDENT → IDENT_VALUE
  - IRADDR → raddr
  - IWADDR → waddr
  - IRDATA → mem_rd_data
  - IFLAGS → flags, zero-extended
  - IWDATA or unknown opcode → 0
- Shifted value v:
  - If bitcnt == DR_WIDTH, v = sr.
  - Otherwise v = sr >> (DR_WIDTH - bitcnt).
  - If bitcnt == 0, v = 0 and COMMIT does nothing, apart from IRDATA's raddr advance below.
- COMMIT by ir:
  - IRADDR → raddr = v
  - IWADDR → waddr = v
  - IWDATA → mem_wr_en = 1 for one clk with mem_wr_addr = waddr and mem_wr_data = v; waddr increments the next cycle and wraps at 2^DR_WIDTH.
  - IRDATA → raddr increments; the read value was already shifted out.
  - IFLAGS → flags = v[FLAG_WIDTH-1:0]
  - IIDENT and unknown opcodes → no effect.
- tdo is registered sr[0] and updates in the same cycle as sr. The TAP samples tdo on tck falling, which is at least 2 clk later.
- The ir value is sampled at capture and held for the whole transaction; ir changes mid-shift are ignored.
- update_dr without a preceding capture (state IDLE) is ignored.
- Reset asserted mid-shift aborts the transaction: no write is issued and partial data is discarded.

Test Plan:
- After reset release: IIDENT capture plus 32 shifts → tdo serialises 0x4A544147 LSB first; flags = 0; no mem_wr_en.
- IWADDR shift 32'h10, then IWDATA shift 32'hE0 (full 32 bits) → one mem_wr_en pulse with addr 0x10, data 0xE0; waddr becomes 0x11.
- IWDATA with only 8 shifts of 0xA5 → written data 0x000000A5 at the current waddr.
- IRADDR shift 0, memory holds mem[0]=0x1234 and mem[1]=0x5678 → two IRDATA transactions return 0x1234 then 0x5678 on tdo; raddr ends at 2.
- IFLAGS shifting 0x40 → flags = 8'h40. A following update_dr with no capture → flags unchanged, no write.
- reset_n pulled low after 10 IWDATA shifts → no mem_wr_en; waddr = 0; a subsequent IIDENT read still returns IDENT_VALUE.
